// File: rtl/noc_arbiter_pkg.sv
// Shared definitions for the NoC output-port arbiter.
//   FID_W / LEN_W          : default flit-id and packet-length widths
//   FID_HEADER/BODY/TAIL   : one-hot flit-id encodings
//   PORT_L..PORT_S         : input port indices (Local first, then N, E, W, S)
//   arb_state_e            : arbiter FSM state encoding
package noc_arbiter_pkg;

   localparam int FID_W = 3;
   localparam int LEN_W = 12;

   localparam logic [FID_W-1:0] FID_HEADER = 3'b001;
   localparam logic [FID_W-1:0] FID_BODY   = 3'b010;
   localparam logic [FID_W-1:0] FID_TAIL   = 3'b100;

   localparam int PORT_L = 0;
   localparam int PORT_N = 1;
   localparam int PORT_E = 2;
   localparam int PORT_W = 3;
   localparam int PORT_S = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

endpackage

// File: rtl/port_hold_timer.sv
// Per-port hold limit and grant-duration counter.
//   clk, rst : clock, synchronous active-high reset
//   flit_id  : head-of-queue flit id of this port
//   length   : packet length, captured as the hold limit on every HEADER flit
//   granted  : this port holds the grant in the next cycle (arbiter next state)
//   timesup  : the current grant has reached its hold limit (limit 0 = unlimited)
module port_hold_timer #(
   parameter int LEN_W = 12,
   parameter int FID_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [FID_W-1:0] flit_id,
   input  logic [LEN_W-1:0] length,
   input  logic             granted,
   output logic             timesup
);
   import noc_arbiter_pkg::*;

   logic [LEN_W-1:0] limit_q, limit_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic             is_header;
   logic             is_tail;

   always_comb begin
      is_header = (flit_id == FID_W'(FID_HEADER));
      is_tail   = (flit_id == FID_W'(FID_TAIL));
      timesup   = (limit_q != '0) && (count_q >= limit_q);
      limit_d   = is_header ? length : limit_q;
      // A non-zero count means this port is granted now. If it is granted
      // again after a tail or an expiry, it was re-won through arbitration
      // (the requester stays asserted), so a fresh grant period starts at 1.
      if (!granted) begin
         count_d = '0;
      end else if ((count_q == '0) || is_tail || timesup) begin
         count_d = LEN_W'(1);
      end else if (&count_q) begin
         count_d = count_q;
      end else begin
         count_d = count_q + LEN_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         limit_q <= '0;
         count_q <= '0;
      end else begin
         limit_q <= limit_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/rr_timeout_arbiter.sv
// Round-robin output-port arbiter with per-packet hold limit.
//   clk, rst    : clock, synchronous active-high reset
//   req         : per-port request
//   flit_id     : per-port head flit id, port 0 in the LSBs
//   length      : per-port packet length, sampled on HEADER flits
//   grant       : registered one-hot grant, zero when idle
//   grant_valid : registered OR of grant
//   grant_idx   : registered index of the granted port, 0 when idle
//   expired     : one-cycle pulse, grant to that port was revoked by timeout
// Handshake: a port owns the output from the cycle after grant rises while
// its req stays high; the grant is withdrawn on req drop, tail or timeout.
module rr_timeout_arbiter #(
   parameter int NPORTS = 5,
   parameter int LEN_W  = noc_arbiter_pkg::LEN_W,
   parameter int FID_W  = noc_arbiter_pkg::FID_W,
   parameter int IDX_W  = $clog2(NPORTS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NPORTS-1:0]       req,
   input  logic [NPORTS*FID_W-1:0] flit_id,
   input  logic [NPORTS*LEN_W-1:0] length,
   output logic [NPORTS-1:0]       grant,
   output logic                    grant_valid,
   output logic [IDX_W-1:0]        grant_idx,
   output logic [NPORTS-1:0]       expired
);
   import noc_arbiter_pkg::*;

   arb_state_e        state_q, state_d;
   logic [NPORTS-1:0] grant_q, grant_d;
   logic              grant_valid_q;
   logic [IDX_W-1:0]  grant_idx_q, idx_d;
   logic [NPORTS-1:0] expired_q, exp_d;
   logic [IDX_W-1:0]  last_q, last_d;

   logic [NPORTS-1:0] tail_c;
   logic [NPORTS-1:0] timesup_c;
   logic              idx_ok_c;
   logic              keep_c;
   logic              arb_c;
   logic [IDX_W-1:0]  start_c;
   logic [IDX_W:0]    pick_c;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] x);
      if (int'(x) >= NPORTS - 1) return '0;
      return x + IDX_W'(1);
   endfunction

   // Returns {found, index} of the first requester at or after start,
   // wrapping. Scanning from the far end lets the nearest hit overwrite.
   function automatic logic [IDX_W:0] rr_pick(input logic [NPORTS-1:0] r,
                                              input logic [IDX_W-1:0]  start);
      logic [IDX_W:0]   res;
      logic [IDX_W-1:0] idx_v;
      int               idx;
      res = '0;
      for (int k = NPORTS - 1; k >= 0; k--) begin
         idx = int'(start) + k;
         if (idx >= NPORTS) idx = idx - NPORTS;
         idx_v = IDX_W'(idx);
         if (r[idx_v]) res = {1'b1, idx_v};
      end
      return res;
   endfunction

   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      assign tail_c[p] = (flit_id[p*FID_W +: FID_W] == FID_W'(FID_TAIL));

      port_hold_timer #(
         .LEN_W(LEN_W),
         .FID_W(FID_W)
      ) u_timer (
         .clk    (clk),
         .rst    (rst),
         .flit_id(flit_id[p*FID_W +: FID_W]),
         .length (length[p*LEN_W +: LEN_W]),
         .granted(grant_d[p]),
         .timesup(timesup_c[p])
      );
   end

   always_comb begin
      state_d  = ST_IDLE;
      grant_d  = '0;
      idx_d    = '0;
      exp_d    = '0;
      last_d   = last_q;
      keep_c   = 1'b0;
      arb_c    = 1'b0;
      start_c  = next_idx(last_q);
      pick_c   = '0;
      idx_ok_c = (int'(grant_idx_q) < NPORTS);
      case (state_q)
         ST_GRANT: begin
            // An out-of-range index falls through to IDLE without arbitrating.
            if (idx_ok_c) begin
               keep_c = req[grant_idx_q] && !tail_c[grant_idx_q] && !timesup_c[grant_idx_q];
               if (keep_c) begin
                  state_d             = ST_GRANT;
                  idx_d               = grant_idx_q;
                  grant_d[grant_idx_q] = 1'b1;
               end else begin
                  // Searching from the next port makes the releasing port last.
                  arb_c               = 1'b1;
                  start_c             = next_idx(grant_idx_q);
                  // Tail wins over timeout when both happen together.
                  exp_d[grant_idx_q]  = req[grant_idx_q] && !tail_c[grant_idx_q] &&
                                        timesup_c[grant_idx_q];
               end
            end
         end
         default: arb_c = 1'b1;
      endcase
      if (arb_c) begin
         pick_c = rr_pick(req, start_c);
         if (pick_c[IDX_W]) begin
            state_d        = ST_GRANT;
            idx_d          = pick_c[IDX_W-1:0];
            grant_d[idx_d] = 1'b1;
            last_d         = idx_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_idx_q   <= '0;
         expired_q     <= '0;
         last_q        <= IDX_W'(NPORTS - 1);
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         grant_valid_q <= |grant_d;
         grant_idx_q   <= idx_d;
         expired_q     <= exp_d;
         last_q        <= last_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign grant_idx   = grant_idx_q;
   assign expired     = expired_q;

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
module tb_rr_timeout_arbiter;

   localparam int NP = 5;
   localparam int LW = 12;
   localparam int FW = 3;
   localparam int IW = 3;
   localparam int W  = NP + 1 + IW + NP;

   localparam logic [FW-1:0] F_HEAD = 3'b001;
   localparam logic [FW-1:0] F_BODY = 3'b010;
   localparam logic [FW-1:0] F_TAIL = 3'b100;

   logic             clk;
   logic             rst;
   logic [NP-1:0]    req;
   logic [NP*FW-1:0] flit_id;
   logic [NP*LW-1:0] length;
   logic [NP-1:0]    grant;
   logic             grant_valid;
   logic [IW-1:0]    grant_idx;
   logic [NP-1:0]    expired;

   logic [W-1:0] exp_q[$];
   int           n_checks;
   int           n_fail;

   rr_timeout_arbiter #(
      .NPORTS(NP),
      .LEN_W (LW),
      .FID_W (FW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .flit_id    (flit_id),
      .length     (length),
      .grant      (grant),
      .grant_valid(grant_valid),
      .grant_idx  (grant_idx),
      .expired    (expired)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
      $fatal(1);
   end

   // expected output word {grant, grant_valid, grant_idx, expired}
   function automatic logic [W-1:0] exp_word(input logic [NP-1:0] g, input logic [NP-1:0] e);
      logic [IW-1:0] ix;
      ix = '0;
      for (int p = 0; p < NP; p++) if (g[p]) ix = IW'(p);
      return {g, |g, ix, e};
   endfunction

   // driver tasks
   task automatic fill_fid(input logic [FW-1:0] v);
      for (int p = 0; p < NP; p++) flit_id[p*FW +: FW] = v;
   endtask

   task automatic set_fid(input int p, input logic [FW-1:0] v);
      flit_id[p*FW +: FW] = v;
   endtask

   task automatic set_len(input int p, input logic [LW-1:0] v);
      length[p*LW +: LW] = v;
   endtask

   task automatic apply_reset;
      rst     = 1'b1;
      req     = '0;
      flit_id = '0;
      length  = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // push the expectation for the coming edge, then sample #1 after it
   task automatic drive_cycle(input logic [NP-1:0] g, input logic [NP-1:0] e);
      exp_q.push_back(exp_word(g, e));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [W-1:0] got_w, exp_w;
      rst = 1'b1;
      req = '1;
      fill_fid(F_HEAD);
      for (int p = 0; p < NP; p++) set_len(p, 12'd5);
      for (int k = 1; k <= 3; k++) begin
         drive_cycle('0, '0);
         exp_w = exp_q.pop_front();
         got_w = {grant, grant_valid, grant_idx, expired};
         n_checks++;
         if (got_w !== exp_w) begin
            n_fail++;
            $display("FAIL reset k=%0d: got %b required %b", k, got_w, exp_w);
         end
      end
   endtask

   task automatic test_hold_and_drop;
      logic [W-1:0]  got_w, exp_w;
      logic [NP-1:0] rq_t[8];
      logic [NP-1:0] g_t[8];
      rq_t = '{5'b00101, 5'b00101, 5'b00101, 5'b00101, 5'b00100, 5'b00100, 5'b00000, 5'b00000};
      g_t  = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00100, 5'b00100, 5'b00000, 5'b00000};
      apply_reset();
      fill_fid(F_BODY);
      for (int k = 0; k < 8; k++) begin
         req = rq_t[k];
         drive_cycle(g_t[k], '0);
         exp_w = exp_q.pop_front();
         got_w = {grant, grant_valid, grant_idx, expired};
         n_checks++;
         if (got_w !== exp_w) begin
            n_fail++;
            $display("FAIL hold_drop k=%0d: got %b required %b", k, got_w, exp_w);
         end
      end
   endtask

   task automatic test_limit_expiry;
      logic [W-1:0]  got_w, exp_w;
      logic [NP-1:0] g_t[6];
      logic [NP-1:0] e_t[6];
      g_t = '{5'b00010, 5'b00010, 5'b00010, 5'b00100, 5'b00100, 5'b00100};
      e_t = '{5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000};
      apply_reset();
      req = 5'b00110;
      for (int k = 0; k < 6; k++) begin
         fill_fid(F_BODY);
         if (k == 0) begin
            set_fid(1, F_HEAD);
            set_len(1, 12'd3);
         end
         drive_cycle(g_t[k], e_t[k]);
         exp_w = exp_q.pop_front();
         got_w = {grant, grant_valid, grant_idx, expired};
         n_checks++;
         if (got_w !== exp_w) begin
            n_fail++;
            $display("FAIL limit_expiry k=%0d: got %b required %b", k, got_w, exp_w);
         end
      end
   endtask

   task automatic test_fairness;
      logic [W-1:0]  got_w, exp_w;
      logic [NP-1:0] one;
      one = 1;
      apply_reset();
      req = '1;
      for (int k = 1; k <= 12; k++) begin
         fill_fid(F_BODY);
         // the port in its 2nd granted cycle presents a tail
         if (k >= 3 && (k % 2) == 1) set_fid(((k - 3) / 2) % NP, F_TAIL);
         drive_cycle(one << (((k - 1) / 2) % NP), '0);
         exp_w = exp_q.pop_front();
         got_w = {grant, grant_valid, grant_idx, expired};
         n_checks++;
         if (got_w !== exp_w) begin
            n_fail++;
            $display("FAIL fairness k=%0d: got %b required %b", k, got_w, exp_w);
         end
      end
   endtask

   task automatic test_single_requester;
      logic [W-1:0] got_w, exp_w;
      apply_reset();
      req = 5'b10000;
      for (int k = 1; k <= 8; k++) begin
         fill_fid(F_BODY);
         if (k == 1) begin
            set_fid(4, F_HEAD);
            set_len(4, 12'd2);
         end
         drive_cycle(5'b10000, (k >= 3 && (k % 2) == 1) ? 5'b10000 : 5'b00000);
         exp_w = exp_q.pop_front();
         got_w = {grant, grant_valid, grant_idx, expired};
         n_checks++;
         if (got_w !== exp_w) begin
            n_fail++;
            $display("FAIL single_req k=%0d: got %b required %b", k, got_w, exp_w);
         end
      end
   endtask

   task automatic test_tail_with_limit;
      logic [W-1:0]  got_w, exp_w;
      logic [FW-1:0] f_t[4];
      logic [NP-1:0] g_t[4];
      f_t = '{F_HEAD, F_BODY, F_TAIL, F_BODY};
      g_t = '{5'b00100, 5'b00100, 5'b01000, 5'b01000};
      apply_reset();
      fill_fid(F_BODY);
      set_len(2, 12'd2);
      req = 5'b01100;
      for (int k = 0; k < 4; k++) begin
         set_fid(2, f_t[k]);
         drive_cycle(g_t[k], '0);
         exp_w = exp_q.pop_front();
         got_w = {grant, grant_valid, grant_idx, expired};
         n_checks++;
         if (got_w !== exp_w) begin
            n_fail++;
            $display("FAIL tail_limit k=%0d: got %b required %b", k, got_w, exp_w);
         end
      end
   endtask

   task automatic test_reset_mid_grant;
      logic [W-1:0]  got_w, exp_w;
      logic          r_t[7];
      logic [NP-1:0] rq_t[7];
      logic [NP-1:0] g_t[7];
      r_t  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      rq_t = '{5'b01000, 5'b01000, 5'b01001, 5'b01001, 5'b01001, 5'b00011, 5'b00011};
      g_t  = '{5'b01000, 5'b01000, 5'b00000, 5'b00001, 5'b00001, 5'b00000, 5'b00001};
      apply_reset();
      fill_fid(F_BODY);
      for (int k = 0; k < 7; k++) begin
         rst = r_t[k];
         req = rq_t[k];
         drive_cycle(g_t[k], '0);
         exp_w = exp_q.pop_front();
         got_w = {grant, grant_valid, grant_idx, expired};
         n_checks++;
         if (got_w !== exp_w) begin
            n_fail++;
            $display("FAIL reset_mid k=%0d: got %b required %b", k, got_w, exp_w);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      req      = '0;
      flit_id  = '0;
      length   = '0;
      test_reset();
      test_hold_and_drop();
      test_limit_expiry();
      test_fairness();
      test_single_requester();
      test_tail_with_limit();
      test_reset_mid_grant();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_timeout_arbiter.md
Name: rr_timeout_arbiter

Overview:
- Parametrised round-robin output-port arbiter for the NoC router. It is the N-port successor to the fixed 5-port L/N/E/W/S arbiter.
- Grants one requesting input at a time and holds the grant while that input keeps requesting.
- A grant is revoked when the per-port hold limit expires or when a tail flit is seen. The hold limit is captured from each packet's header length.
- Sits between the input buffers and the crossbar select logic. Grant outputs are registered.

Parameters:
- NPORTS, 5, number of requesting inputs; index 0 is Local, then N, E, W, S.
- LEN_W, 12, width of the length field and of the hold counter.
- FID_W, 3, flit-id width.
- IDX_W, $clog2(NPORTS), width of the grant index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NPORTS  per-port request.
- flit_id  in  NPORTS*FID_W  per-port flit id of the head-of-queue flit, packed with port 0 in the LSBs.
- length  in  NPORTS*LEN_W  per-port packet length, valid when that port's flit_id is HEADER.
- grant  out  NPORTS  registered one-hot grant; all zeros when idle.
- grant_valid  out  1  registered; equals OR of grant.
- grant_idx  out  IDX_W  registered index of the granted port; 0 when idle.
- expired  out  NPORTS  one-cycle pulse: the grant to this port was revoked by timeout.

Behaviour:
- Reset: grant=0, grant_valid=0, grant_idx=0, expired=0, all hold limits=0, all counters=0, last-served pointer=NPORTS-1. This makes port 0 highest priority after reset.
- Limit capture: for each port p, every cycle in which flit_id[p]==FID_HEADER, limit[p] <= length[p]. Capture is independent of grant state. A capture made while p is granted takes effect in the next cycle's comparison.
- limit[p]==0 means unlimited hold.
- States: IDLE (no grant) and GRANT(i). One state register plus the grant_idx encoding.
- Arbitration search: over req, starting at (last+1) mod NPORTS and wrapping; the first requester found wins. No requester selects IDLE. last <= winner on every new grant.
- IDLE: if any req is set, then next cycle grant=onehot(winner) and count[winner]=1.
- GRANT(i), keep condition: req[i] && !tail[i] && !(limit[i]!=0 && count[i]>=limit[i]), where tail[i] = (flit_id[i]==FID_TAIL).
  - Keep: grant unchanged, count[i] increments, saturating at all-ones.
  - Release: re-arbitrate in the same cycle from (i+1) mod NPORTS. Port i itself is eligible last.
  - Release result: the new grant appears next cycle, with no idle bubble, or the block goes to IDLE.
  - If release was due to the limit, expired[i]=1 for exactly one cycle, coincident with the new grant.
- Hold length: a port with limit L≠0 and a continuous request holds the grant for exactly L consecutive cycles.
- Latency: req to grant is 1 cycle. Dropping req deasserts grant 1 cycle later.
- Counter: count[p] is zeroed on every cycle p is not granted.
- Simultaneous tail and limit expiry: treated as a tail release; expired is not pulsed.
- Single requester with an expired limit: it is re-granted immediately via wrap-around, count restarts at 1, and expired pulses.
- Reset mid-grant: all state returns to reset values on the next edge; the pointer resets too.
- grant is one-hot or zero at all times.
- Out-of-range grant_idx, which should be unreachable, forces IDLE.

Decomposition:
- Shared package noc_arbiter_pkg: FID_W, FID_HEADER=3'b001, FID_BODY=3'b010, FID_TAIL=3'b100, default LEN_W, port index constants PORT_L..PORT_S.
- Sub-module port_hold_timer, instantiated NPORTS times.
  - Inputs: clk, rst, flit_id, length, granted.
  - Output: timesup = (limit!=0 && count>=limit).
  - Holds limit[p] and count[p].
- Round-robin search is a combinational function inside the top module.

Test Plan:
- Reset, then req=5'b00101 held constant, all limits 0: grant=00001 on cycle 1 and stays. Drop req[0]: grant=00100 next cycle.
- Port 1 header with length=3, req=5'b00110 continuous: grant 00010 for exactly 3 cycles, then 00100 with expired=00010 for one cycle.
- Round-robin fairness: req=5'b11111, every port uses a tail on its 2nd granted cycle. Grant order is 0,1,2,3,4,0, each held 2 cycles, no idle cycles.
- Single requester, port 4 with limit 2, continuous req: grant stays 10000. expired[4] pulses every 2 cycles; count restarts at 1.
- Tail and limit expiry in the same cycle on port 2 with req[3] set: grant moves to 01000 and expired stays 0.
- Assert rst while port 3 is granted: next cycle grant=0, grant_valid=0. With req=5'b01001 after reset, port 0 wins first.
